// File: rtl/spi_drivers_pkg.sv
// Shared definitions for the SPI master/slave driver pair.
// Holds the default SCLK half-period, frame width and the master state type.
package spi_drivers_pkg;

    localparam int unsigned SCLK_HALF_DEFAULT = 4;
    localparam int unsigned FRAME_W           = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } master_state_e;

endpackage

// File: rtl/spi_drivers_sync.sv
// Two-flop synchronizer for one asynchronous input, with a selectable reset level.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_master_driver.sv
// SPI mode-0 master: MSB-first 8-bit full-duplex frames, SCLK derived from clk_i.
// MOSI is the MSB of the transmit shift register, so it is always a flop output.
module spi_master_driver
    import spi_drivers_pkg::*;
#(
    parameter int unsigned SCLK_HALF = SCLK_HALF_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] data_in_bi,
    output logic               busy_o,
    output logic [FRAME_W-1:0] data_out_bo,
    input  logic               spi_miso_i,
    output logic               spi_mosi_o,
    output logic               spi_sclk_o,
    output logic               spi_cs_o
);

    localparam int unsigned CNT_W = $clog2(2 * SCLK_HALF);
    localparam int unsigned BIT_W = $clog2(FRAME_W);

    master_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] dout_q, dout_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_XFER;
                    tx_d    = data_in_bi;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_XFER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCLK_HALF - 1)) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[FRAME_W-2:0], spi_miso_i};
                end else if (cnt_q == CNT_W'(2 * SCLK_HALF - 1)) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    // The last falling edge also closes the frame in the same cycle.
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = ST_IDLE;
                        tx_d    = '0;
                        cs_d    = 1'b1;
                        busy_d  = 1'b0;
                        dout_d  = rx_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign data_out_bo = dout_q;
    assign spi_mosi_o  = tx_q[FRAME_W-1];
    assign spi_sclk_o  = sclk_q;
    assign spi_cs_o    = cs_q;

endmodule

// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave: oversamples SCLK/CS/MOSI through synchronizers and works on
// edges of the synchronized copies. MISO is the MSB of the transmit shift register.
module spi_slave_driver
    import spi_drivers_pkg::*;
#(
    parameter int unsigned SCLK_HALF = SCLK_HALF_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [FRAME_W-1:0] data_in_bi,
    output logic               ready_o,
    output logic [FRAME_W-1:0] data_out_bo,
    output logic               spi_miso_o,
    input  logic               spi_mosi_i,
    input  logic               spi_sclk_i,
    input  logic               spi_cs_i
);

    localparam int unsigned BIT_W = $clog2(FRAME_W);

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_sclk_i),
        .q_o   (sclk_s)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_cs_i),
        .q_o   (cs_s)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_mosi_i),
        .q_o   (mosi_s)
    );

    logic               sclk_prev_q, sclk_prev_d;
    logic               cs_prev_q, cs_prev_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-2:0] rx_q, rx_d;
    logic [FRAME_W-1:0] dout_q, dout_d;
    logic               ready_q, ready_d;

    always_comb begin
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        dout_d      = dout_q;
        ready_d     = 1'b0;

        // CS edges take priority so the final SCLK fall never re-drives MISO after deselect.
        if (cs_prev_q && !cs_s) begin
            tx_d  = data_in_bi;
            bit_d = '0;
        end else if (!cs_prev_q && cs_s) begin
            tx_d  = '0;
            bit_d = '0;
        end else if (!cs_s) begin
            if (!sclk_prev_q && sclk_s) begin
                rx_d  = {rx_q[FRAME_W-3:0], mosi_s};
                bit_d = bit_q + 1'b1;
                if (bit_q == BIT_W'(FRAME_W - 1)) begin
                    dout_d  = {rx_q, mosi_s};
                    ready_d = 1'b1;
                    bit_d   = '0;
                end
            end else if (sclk_prev_q && !sclk_s) begin
                tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            dout_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
        end
    end

    assign ready_o     = ready_q;
    assign data_out_bo = dout_q;
    assign spi_miso_o  = tx_q[FRAME_W-1];

endmodule

// File: rtl/spi_drivers.sv
// Wrapper exposing an SPI master and an SPI slave side by side; the SPI bus
// pins of both are brought out so they can be looped back or driven separately.
module spi_drivers
    import spi_drivers_pkg::*;
#(
    parameter int unsigned SCLK_HALF = SCLK_HALF_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m_start_i,
    input  logic [FRAME_W-1:0] m_data_in_bi,
    output logic               m_busy_o,
    output logic [FRAME_W-1:0] m_data_out_bo,
    input  logic               m_spi_miso_i,
    output logic               m_spi_mosi_o,
    output logic               m_spi_sclk_o,
    output logic               m_spi_cs_o,
    input  logic [FRAME_W-1:0] s_data_in_bi,
    output logic               s_ready_o,
    output logic [FRAME_W-1:0] s_data_out_bo,
    output logic               s_spi_miso_o,
    input  logic               s_spi_mosi_i,
    input  logic               s_spi_sclk_i,
    input  logic               s_spi_cs_i
);

    spi_master_driver #(.SCLK_HALF(SCLK_HALF)) u_master (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (m_start_i),
        .data_in_bi  (m_data_in_bi),
        .busy_o      (m_busy_o),
        .data_out_bo (m_data_out_bo),
        .spi_miso_i  (m_spi_miso_i),
        .spi_mosi_o  (m_spi_mosi_o),
        .spi_sclk_o  (m_spi_sclk_o),
        .spi_cs_o    (m_spi_cs_o)
    );

    spi_slave_driver #(.SCLK_HALF(SCLK_HALF)) u_slave (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_in_bi  (s_data_in_bi),
        .ready_o     (s_ready_o),
        .data_out_bo (s_data_out_bo),
        .spi_miso_o  (s_spi_miso_o),
        .spi_mosi_i  (s_spi_mosi_i),
        .spi_sclk_i  (s_spi_sclk_i),
        .spi_cs_i    (s_spi_cs_i)
    );

endmodule

// File: tb/tb_spi_drivers.sv
// Directed + randomized bench for spi_drivers: master/slave loopback and slave driven alone.
module tb_spi_drivers;

    localparam int H         = 4;
    localparam int FRAME_CYC = 16 * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       m_start;
    logic [7:0] m_din, s_din;
    logic       m_busy, m_mosi, m_sclk, m_cs;
    logic [7:0] m_dout, s_dout;
    logic       s_ready, s_miso;
    logic       loop_mode;
    logic       tb_sclk, tb_cs, tb_mosi;
    logic       s_sclk_in, s_cs_in, s_mosi_in;

    assign s_sclk_in = loop_mode ? m_sclk : tb_sclk;
    assign s_cs_in   = loop_mode ? m_cs   : tb_cs;
    assign s_mosi_in = loop_mode ? m_mosi : tb_mosi;

    spi_drivers #(.SCLK_HALF(H)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .m_start_i     (m_start),
        .m_data_in_bi  (m_din),
        .m_busy_o      (m_busy),
        .m_data_out_bo (m_dout),
        .m_spi_miso_i  (s_miso),
        .m_spi_mosi_o  (m_mosi),
        .m_spi_sclk_o  (m_sclk),
        .m_spi_cs_o    (m_cs),
        .s_data_in_bi  (s_din),
        .s_ready_o     (s_ready),
        .s_data_out_bo (s_dout),
        .s_spi_miso_o  (s_miso),
        .s_spi_mosi_i  (s_mosi_in),
        .s_spi_sclk_i  (s_sclk_in),
        .s_spi_cs_i    (s_cs_in)
    );

    // Bus monitor: cycle counts, SCLK pulses and the MOSI byte seen at each rising SCLK.
    int         busy_cyc   = 0;
    int         cs_low_cyc = 0;
    int         sclk_rises = 0;
    int         ready_cnt  = 0;
    logic [7:0] mosi_cap   = 8'h00;
    logic       prev_sclk  = 1'b0;

    always @(negedge clk) begin
        if (m_busy) busy_cyc++;
        if (!m_cs) cs_low_cyc++;
        if (m_sclk && !prev_sclk) begin
            sclk_rises++;
            mosi_cap = {mosi_cap[6:0], m_mosi};
        end
        prev_sclk = m_sclk;
        if (s_ready) ready_cnt++;
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_level(input string tag, input int which, input logic val, input int limit);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = (m_busy === val);
                1:       hit = (m_cs === val);
                default: hit = (s_ready === val);
            endcase
        end
        chk({tag, "_wait"}, 32'(hit), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"},     32'(m_cs),    32'd1);
        chk({tag, "_sclk"},   32'(m_sclk),  32'd0);
        chk({tag, "_mosi"},   32'(m_mosi),  32'd0);
        chk({tag, "_busy"},   32'(m_busy),  32'd0);
        chk({tag, "_mdout"},  32'(m_dout),  32'd0);
        chk({tag, "_smiso"},  32'(s_miso),  32'd0);
        chk({tag, "_sready"}, 32'(s_ready), 32'd0);
        chk({tag, "_sdout"},  32'(s_dout),  32'd0);
    endtask

    // One full loopback frame; data inputs and start are disturbed mid-frame and must be ignored.
    task automatic do_xfer(input logic [7:0] mb, input logic [7:0] sb, input string tag);
        int b0, c0, k0, r0;
        @(negedge clk); #1;
        m_din = mb; s_din = sb; m_start = 1'b1;
        b0 = busy_cyc; c0 = cs_low_cyc; k0 = sclk_rises; r0 = ready_cnt;
        @(negedge clk); #1;
        m_start = 1'b0;
        m_din   = ~mb;
        repeat (8) @(negedge clk);
        #1;
        s_din   = ~sb;
        m_start = 1'b1;
        @(negedge clk); #1;
        m_start = 1'b0;
        wait_level({tag, "_done"}, 0, 1'b0, 200);
        repeat (12) @(negedge clk);
        #1;
        chk({tag, "_busy_len"},  32'(busy_cyc - b0),   32'(FRAME_CYC));
        chk({tag, "_cs_len"},    32'(cs_low_cyc - c0), 32'(FRAME_CYC));
        chk({tag, "_sclk_cnt"},  32'(sclk_rises - k0), 32'd8);
        chk({tag, "_ready_cnt"}, 32'(ready_cnt - r0),  32'd1);
        chk({tag, "_mosi_bits"}, 32'(mosi_cap),        32'(mb));
        chk({tag, "_m_dout"},    32'(m_dout),          32'(sb));
        chk({tag, "_s_dout"},    32'(s_dout),          32'(mb));
    endtask

    // Slave driven directly: n bits of v, MSB first; MISO sampled just before each rising SCLK.
    task automatic slave_bits(input logic [7:0] v, input int n, output logic [7:0] miso_seen);
        logic [7:0] sh;
        sh = v;
        miso_seen = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            tb_mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            repeat (H) @(negedge clk);
            miso_seen = {miso_seen[6:0], s_miso};
            #1 tb_sclk = 1'b1;
            repeat (H) @(negedge clk);
            #1 tb_sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, c0, k0, r0, n;
        logic [7:0] mb, sb, seen;

        rst = 1'b0; m_start = 1'b1; m_din = 8'hAC; s_din = 8'hA5;
        loop_mode = 1'b1; tb_sclk = 1'b0; tb_cs = 1'b1; tb_mosi = 1'b0;

        // Reset with start already requested.
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst");

        b0 = busy_cyc; c0 = cs_low_cyc; k0 = sclk_rises; r0 = ready_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_busy", 32'(m_busy), 32'd1);
        chk("rel_cs",   32'(m_cs),   32'd0);
        chk("rel_mosi", 32'(m_mosi), 32'd1);
        repeat (4) @(negedge clk);
        #1 m_start = 1'b0;
        wait_level("rel_done", 0, 1'b0, 200);
        repeat (20) @(negedge clk);
        #1;
        chk("rel_busy_len",  32'(busy_cyc - b0),   32'(FRAME_CYC));
        chk("rel_cs_len",    32'(cs_low_cyc - c0), 32'(FRAME_CYC));
        chk("rel_sclk_cnt",  32'(sclk_rises - k0), 32'd8);
        chk("rel_ready_cnt", 32'(ready_cnt - r0),  32'd1);
        chk("rel_mosi_bits", 32'(mosi_cap),        32'h000000AC);
        chk("rel_m_dout",    32'(m_dout),          32'h000000A5);
        chk("rel_s_dout",    32'(s_dout),          32'h000000AC);

        do_xfer(8'hA5, 8'hAC, "swap");

        for (int t = 0; t < 4; t++) begin
            mb = 8'($urandom);
            sb = 8'($urandom);
            do_xfer(mb, sb, $sformatf("rnd%0d", t));
        end

        // start held high: back-to-back frames separated by one deselected cycle.
        mb = 8'($urandom);
        sb = 8'($urandom);
        @(negedge clk); #1;
        m_din = mb; s_din = sb; m_start = 1'b1;
        r0 = ready_cnt;
        wait_level("b2b_start", 0, 1'b1, 5);
        wait_level("b2b_gap", 1, 1'b1, 200);
        n = 0;
        while (m_cs === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_gap_len",  32'(n),      32'd1);
        chk("b2b_m_dout1",  32'(m_dout), 32'(sb));
        #1 m_start = 1'b0;
        wait_level("b2b_done", 0, 1'b0, 200);
        repeat (12) @(negedge clk);
        #1;
        chk("b2b_m_dout2", 32'(m_dout),          32'(sb));
        chk("b2b_s_dout",  32'(s_dout),          32'(mb));
        chk("b2b_ready",   32'(ready_cnt - r0),  32'd2);

        // Reset asserted between the 4th and 5th bit.
        @(negedge clk); #1;
        m_din = 8'($urandom); s_din = 8'($urandom); m_start = 1'b1;
        @(negedge clk); #1;
        m_start = 1'b0;
        repeat (8 * H + 2) @(negedge clk);
        r0 = ready_cnt;
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("midrst_ready", 32'(ready_cnt - r0), 32'd0);
        chk("midrst_mdout", 32'(m_dout),         32'd0);
        chk("midrst_sdout", 32'(s_dout),         32'd0);
        do_xfer(8'h3C, 8'hC3, "post_rst");

        // Slave alone: aborted partial frame, then a full 0x5A frame.
        @(negedge clk); #1;
        loop_mode = 1'b1;
        loop_mode = 1'b0;
        r0 = ready_cnt;
        s_din = 8'($urandom);
        repeat (4) @(negedge clk);
        #1 tb_cs = 1'b0;
        repeat (8) @(negedge clk);
        slave_bits(8'hFF, 5, seen);
        #1 tb_cs = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("partial_ready", 32'(ready_cnt - r0), 32'd0);
        chk("partial_sdout", 32'(s_dout),         32'h0000003C);
        chk("partial_miso",  32'(s_miso),         32'd0);

        sb = 8'($urandom);
        s_din = sb;
        r0 = ready_cnt;
        #1 tb_cs = 1'b0;
        repeat (8) @(negedge clk);
        slave_bits(8'h5A, 8, seen);
        #1 tb_cs = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("solo_ready", 32'(ready_cnt - r0), 32'd1);
        chk("solo_sdout", 32'(s_dout),         32'h0000005A);
        chk("solo_miso",  32'(seen),           32'(sb));
        chk("solo_idle",  32'(s_miso),         32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
